key_step_conditioner: RTL and testbench
=======================================

// Module: key_step_conditioner
// PURPOSE
// - Converts one raw, bouncing, active-low DE2 pushbutton (KEY[n]) into a clean,
//   clock-synchronous single-cycle step strobe plus a debounced level.
// - Sits directly upstream of the Processor step input. It replaces the
//   ButtonSync->KeyFilter pair in Project with one block that has an optional auto-repeat.
// - PressCount gives the top level a press counter to show on a spare HEX pair.
// PARAMETERS
// - SYNC_STAGES      2           metastability flops on KeyN (>=2)
// - DEBOUNCE_CYCLES  1_000_000   stable-sample cycles required to accept a press or release (20 ms @ 50 MHz)
// - REPEAT_DELAY     25_000_000  HELD cycles from the initial Pulse to the first repeat Pulse (500 ms)
// - REPEAT_PERIOD    5_000_000   cycles between subsequent repeat Pulses (100 ms)
// PORTS
// - Clk         in   1  system clock (CLOCK_50 at top level)
// - ResetN      in   1  synchronous, active-low reset
// - KeyN        in   1  raw pushbutton; 0 = pressed, asynchronous, bouncing
// - RepeatEn    in   1  1 = auto-repeat while held (synchronous, from SW)
// - Pressed     out  1  debounced level; 1 while the button is accepted as held
// - Pulse       out  1  one-Clk strobe per accepted press and per repeat
// - PressCount  out  8  number of Pulses issued, modulo 256
// BEHAVIOUR
// - Reset: while ResetN=0 at a rising edge, the following apply.
//   - Sync flops load 1 (released). FSM goes to IDLE.
//   - All counters load 0. Pressed=0, Pulse=0, PressCount=0.
// - After reset release, a key that is still held is treated as a new press:
//   full debounce, then a Pulse.
// - All outputs are registered. There are no combinational paths from input to output.
// - ks = output of the last sync stage. dcnt = debounce counter. rcnt = repeat counter.
// - FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
//   - IDLE: ks=0 -> PRESS_DB, dcnt<=0.
//   - PRESS_DB: ks=1 -> IDLE (bounce, no output).
//     Else if dcnt==DEBOUNCE_CYCLES-1 -> HELD. Else dcnt++.
//   - HELD: ks=1 -> RELEASE_DB, dcnt<=0.
//   - RELEASE_DB: ks=0 -> HELD (bounce; no Pulse, rcnt resumes).
//     Else if dcnt==DEBOUNCE_CYCLES-1 -> IDLE. Else dcnt++.
// - Pressed=1 exactly when the registered state is HELD or RELEASE_DB.
// - Pulse on press: Pulse=1 on the same edge as the PRESS_DB->HELD transition.
//   - Clean press latency: KeyN sampled low at edge 1 gives Pulse=1 after edge
//     SYNC_STAGES+DEBOUNCE_CYCLES+1.
// - Repeat pulses:
//   - rcnt loads 0 on entry to HELD from PRESS_DB.
//   - rcnt counts in HELD only while RepeatEn=1. It holds while RepeatEn=0 and
//     while in RELEASE_DB.
//   - First repeat Pulse fires when rcnt reaches REPEAT_DELAY-1; rcnt then reloads 0.
//   - Later repeat Pulses fire at REPEAT_PERIOD-1, with a reload each time.
// - Pulse is never high for two consecutive cycles. Pulse never fires in IDLE,
//   PRESS_DB or RELEASE_DB.
// - PressCount increments on each Pulse and wraps 255->0 with no flag.
// - Counter widths are $clog2 of the largest value compared against. There is no overflow path.
// - Parameter guard: an elaboration-time $error fires if any of the following is less than
//   its minimum: DEBOUNCE_CYCLES<1, REPEAT_PERIOD<2, SYNC_STAGES<2.
// STRUCTURE
// - key_cond_pkg holds two items:
//   - typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} kc_state_t.
//   - The function cnt_w(max) returning $clog2(max+1).
// - Sub-module sync_chain #(STAGES, RESET_VAL) (Clk, ResetN, D, Q):
//   - Generic N-flop synchronizer.
//   - Reusable for the other KEY inputs.
// - The top level has one FSM always_ff, one dcnt, one rcnt and one output register group.
// TESTING  (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
// - Clean press: KeyN 1->0 at edge 1 and held -> Pulse=1 only after edge 7.
//   Pressed=1 from edge 7. PressCount=1.
// - Press bounce: KeyN low 3 cycles, high 1, then low and held ->
//   no Pulse before the final low run. Exactly one Pulse, 7 edges after the final falling sample.
// - Release bounce: from HELD, KeyN high 2 cycles, low 1, then high ->
//   no extra Pulse. Pressed stays 1 until 4 stable high samples, then 0.
// - Auto-repeat: RepeatEn=1, hold 30 cycles past the first Pulse ->
//   repeat Pulses at +10, +13, +16, ... PressCount matches the Pulse total.
//   With RepeatEn=0 only one Pulse occurs.
// - Reset mid-press: ResetN=0 for 1 edge while in HELD with KeyN still 0 ->
//   all outputs 0 next cycle. After release, a new Pulse comes 7 edges later and PressCount=1.
// - Wrap: 256 clean presses -> PressCount returns to 0. Pulse is never high for 2 consecutive cycles (assertion).

Source files
------------

// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared state encoding and counter-width helper for pushbutton conditioning
package key_cond_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} kc_state_t;
   function automatic int cnt_w(input int max);
      return $clog2(max + 1);
   endfunction
endpackage

// File: rtl/key_step_conditioner_sync.sv
// sync_chain: generic N-flop synchronizer with a selectable reset value
module sync_chain #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
)(
   input  logic Clk,
   input  logic ResetN,
   input  logic D,
   output logic Q
);
   logic [STAGES-1:0] q_r;
   always_ff @(posedge Clk)
      if (!ResetN) q_r <= {STAGES{RESET_VAL}};
      else q_r <= {q_r[STAGES-2:0], D};
   assign Q = q_r[STAGES-1];
endmodule

// File: rtl/key_step_conditioner.sv
// key_step_conditioner: debounced level, press/auto-repeat strobe and press counter for one active-low key
module key_step_conditioner
   import key_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
)(
   input  logic       Clk,
   input  logic       ResetN,
   input  logic       KeyN,
   input  logic       RepeatEn,
   output logic       Pressed,
   output logic       Pulse,
   output logic [7:0] PressCount
);
   localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DW = cnt_w(DEBOUNCE_CYCLES);
   localparam int RW = cnt_w(RMAX);
   localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
   if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 2 || SYNC_STAGES < 2) begin : g_bad_params
      $error("key_step_conditioner: DEBOUNCE_CYCLES>=1, REPEAT_PERIOD>=2, SYNC_STAGES>=2 required");
   end
   kc_state_t state, state_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic first, first_n, pulse_n, ks;
   sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
      .Clk(Clk), .ResetN(ResetN), .D(KeyN), .Q(ks)
   );
   // first selects the long initial repeat delay until the first repeat has fired
   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      rcnt_n  = rcnt;
      first_n = first;
      pulse_n = 1'b0;
      case (state)
         IDLE:
            if (!ks) begin state_n = PRESS_DB; dcnt_n = '0; end
         PRESS_DB:
            if (ks) state_n = IDLE;
            else if (dcnt == D_LAST) begin
               state_n = HELD;
               rcnt_n  = '0;
               first_n = 1'b1;
               pulse_n = 1'b1;
            end
            else dcnt_n = dcnt + 1'b1;
         HELD:
            if (ks) begin state_n = RELEASE_DB; dcnt_n = '0; end
            else if (RepeatEn) begin
               if (rcnt == (first ? RD_LAST : RP_LAST)) begin
                  rcnt_n  = '0;
                  first_n = 1'b0;
                  pulse_n = 1'b1;
               end
               else rcnt_n = rcnt + 1'b1;
            end
         RELEASE_DB:
            if (!ks) state_n = HELD;
            else if (dcnt == D_LAST) state_n = IDLE;
            else dcnt_n = dcnt + 1'b1;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge Clk)
      if (!ResetN) begin
         state      <= IDLE;
         dcnt       <= '0;
         rcnt       <= '0;
         first      <= 1'b1;
         Pressed    <= 1'b0;
         Pulse      <= 1'b0;
         PressCount <= '0;
      end else begin
         state      <= state_n;
         dcnt       <= dcnt_n;
         rcnt       <= rcnt_n;
         first      <= first_n;
         Pressed    <= (state_n == HELD) || (state_n == RELEASE_DB);
         Pulse      <= pulse_n;
         PressCount <= PressCount + 8'(pulse_n);
      end
endmodule

// File: tb/tb_key_step_conditioner.sv
// tb_key_step_conditioner: table vectors plus pulse-timing scoreboard for key_step_conditioner
module tb_key_step_conditioner;
   logic Clk = 1'b0;
   logic ResetN, KeyN, RepeatEn;
   logic Pressed, Pulse;
   logic [7:0] PressCount;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];
   logic prev_pulse = 1'b0;

   typedef struct {
      logic       key;
      logic       rep;
      logic       pressed;
      logic       pulse;
      logic [7:0] cnt;
   } vec_t;
   vec_t vecs[17];

   key_step_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut (
      .Clk(Clk), .ResetN(ResetN), .KeyN(KeyN), .RepeatEn(RepeatEn),
      .Pressed(Pressed), .Pulse(Pulse), .PressCount(PressCount)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // every Pulse must match the earliest scheduled cycle in the scoreboard
   always @(negedge Clk) begin
      if (Pulse === 1'b1) begin
         chk("pulse_gap", {31'd0, prev_pulse}, 0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: Pulse=1 at cycle %0d, required 0", cyc);
         end
         else chk("pulse_cycle", cyc, exp_q.pop_front());
      end
      prev_pulse <= Pulse;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   initial begin
      vecs = '{
         '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0}, '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0}, '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0}, '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1}, '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1},
         '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1}, '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1},
         '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1}, '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1},
         '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1}, '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1},
         '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1}, '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
         '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1}
      };
      ResetN = 1'b0; KeyN = 1'b1; RepeatEn = 1'b0;
      wait_cyc(3);
      chk("rst_pressed", {31'd0, Pressed}, 0);
      chk("rst_pulse", {31'd0, Pulse}, 0);
      chk("rst_count", {24'd0, PressCount}, 0);
      ResetN = 1'b1;
      wait_cyc(1);
      // clean press and clean release, one row per clock edge
      foreach (vecs[i]) begin
         KeyN = vecs[i].key;
         RepeatEn = vecs[i].rep;
         if (vecs[i].pulse) exp_q.push_back(cyc + 1);
         wait_cyc(1);
         chk($sformatf("vec%0d_pressed", i), {31'd0, Pressed}, {31'd0, vecs[i].pressed});
         chk($sformatf("vec%0d_count", i), {24'd0, PressCount}, {24'd0, vecs[i].cnt});
      end
      // press bounce: 3 low, 1 high, then held low
      KeyN = 1'b0;
      wait_cyc(3);
      KeyN = 1'b1;
      wait_cyc(1);
      KeyN = 1'b0;
      exp_q.push_back(cyc + 7);
      wait_cyc(9);
      chk("bounce_count", {24'd0, PressCount}, 2);
      chk("bounce_pressed", {31'd0, Pressed}, 1);
      // release bounce: 2 high, 1 low, then held high
      KeyN = 1'b1;
      wait_cyc(2);
      KeyN = 1'b0;
      wait_cyc(1);
      KeyN = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_cyc(1);
         chk("relbounce_pressed_hold", {31'd0, Pressed}, 1);
      end
      wait_cyc(1);
      chk("relbounce_pressed_drop", {31'd0, Pressed}, 0);
      chk("relbounce_count", {24'd0, PressCount}, 2);
      // auto-repeat: initial pulse then repeats at +10, +13, ... while held
      RepeatEn = 1'b1;
      KeyN = 1'b0;
      exp_q.push_back(cyc + 7);
      for (int k = 0; k < 8; k++) exp_q.push_back(cyc + 17 + 3 * k);
      wait_cyc(37);
      KeyN = 1'b1;
      wait_cyc(10);
      chk("repeat_count", {24'd0, PressCount}, 11);
      chk("repeat_released", {31'd0, Pressed}, 0);
      // same hold without repeat enabled gives a single pulse
      RepeatEn = 1'b0;
      KeyN = 1'b0;
      exp_q.push_back(cyc + 7);
      wait_cyc(37);
      KeyN = 1'b1;
      wait_cyc(10);
      chk("norepeat_count", {24'd0, PressCount}, 12);
      // reset while held, key still down afterwards
      KeyN = 1'b0;
      exp_q.push_back(cyc + 7);
      wait_cyc(10);
      ResetN = 1'b0;
      wait_cyc(1);
      chk("midrst_pressed", {31'd0, Pressed}, 0);
      chk("midrst_pulse", {31'd0, Pulse}, 0);
      chk("midrst_count", {24'd0, PressCount}, 0);
      ResetN = 1'b1;
      exp_q.push_back(cyc + 7);
      wait_cyc(9);
      chk("midrst_repress_count", {24'd0, PressCount}, 1);
      chk("midrst_repress_pressed", {31'd0, Pressed}, 1);
      KeyN = 1'b1;
      wait_cyc(10);
      // 256 presses from zero wrap the counter back to zero
      ResetN = 1'b0;
      wait_cyc(1);
      ResetN = 1'b1;
      for (int i = 0; i < 256; i++) begin
         KeyN = 1'b0;
         exp_q.push_back(cyc + 7);
         wait_cyc(8);
         KeyN = 1'b1;
         wait_cyc(8);
         if (i == 254) chk("wrap_count_255", {24'd0, PressCount}, 255);
      end
      chk("wrap_count_0", {24'd0, PressCount}, 0);
      chk("pending_pulses", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
